// File: rtl/instr_byte_loader.sv
// rtl/instr_byte_loader.sv - byte-serial instruction loader packing bytes into 32-bit imem words
// Optional checksum feature: define LOADER_CHECKSUM_EN to add checksum_o / checksum_ok_o.
module instr_byte_loader #(
  parameter int         DEPTH      = 64,
  parameter int         ADDR_W     = 6,
  parameter logic [7:0] START_BYTE = 8'hFE
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic [ADDR_W:0]   word_cnt_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o,
  output logic              checksum_ok_o
`endif
);

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] L_LAST  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_byte_cnt;
  logic [1:0]        w_byte_cnt_nxt;
  logic [23:0]       r_shift;
  logic [23:0]       w_shift_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst;
  logic              r_done;
  logic [ADDR_W:0]   r_word_cnt;
  logic [31:0]       w_word;
  logic              w_wr;
  logic              w_end_hit;

  // The fourth byte completes the word combinationally with the three held bytes.
  assign w_word = {r_shift, instr_i};

  // State register and byte packing registers.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state    <= IDLE;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  // Next-state logic: marker detection, MS-first byte packing, end/full detection.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_shift_nxt    = r_shift;
    w_wr           = 1'b0;
    w_end_hit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (instr_i == START_BYTE) begin
          w_state_nxt    = LOAD;
          w_byte_cnt_nxt = 2'd0;
          w_shift_nxt    = 24'd0;
        end
      end
      LOAD: begin
        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
        w_shift_nxt    = {r_shift[15:0], instr_i};
        if (r_byte_cnt == 2'd3) begin
          if (w_word == 32'hFFFF_FFFF) begin
            w_state_nxt = DONE;
            w_end_hit   = 1'b1;
          end else begin
            w_wr = 1'b1;
            // The write filling the last slot ends the load; no address wrap.
            if (r_word_cnt == L_LAST) begin
              w_state_nxt = DONE;
            end
          end
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Write port, word counter and CPU-reset/done status registers.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_addr  <= r_word_cnt[ADDR_W-1:0];
        r_wdata <= w_word;
      end
      // The counter trails the write pulse by one cycle and saturates at DEPTH.
      if (r_we && (r_word_cnt != L_DEPTH)) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      r_done    <= (r_state == DONE);
      r_cpu_rst <= (r_state != DONE);
    end
  end

  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_wdata;
  assign cpu_rst_o    = r_cpu_rst;
  assign load_done_o  = r_done;
  assign word_cnt_o   = r_word_cnt;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;
  logic        r_checksum_ok;

  // Running XOR of written words; the sender's trailing checksum word cancels it to zero.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_checksum    <= 32'd0;
      r_checksum_ok <= 1'b0;
    end else begin
      if (r_we) begin
        r_checksum <= r_checksum ^ r_wdata;
      end
      if (w_end_hit) begin
        r_checksum_ok <= (r_checksum == 32'd0) && (r_word_cnt != '0);
      end
    end
  end

  assign checksum_o    = r_checksum;
  assign checksum_ok_o = r_checksum_ok;
`endif

endmodule

// File: tb/tb_instr_byte_loader.sv
// tb/tb_instr_byte_loader.sv - scoreboard bench for instr_byte_loader
module tb_instr_byte_loader;

  logic        clk_i;
  logic        reset;
  logic [7:0]  instr_i;
  logic        imem_we_o;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        cpu_rst_o;
  logic        load_done_o;
  logic [6:0]  word_cnt_o;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_o;
  logic        checksum_ok_o;
`endif

  int total;
  int bad;
  logic [5:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic        prev_we;
  bit          sim_end;

  instr_byte_loader #(
    .DEPTH(64),
    .ADDR_W(6),
    .START_BYTE(8'hFE)
  ) dut (
    .clk_i(clk_i),
    .reset(reset),
    .instr_i(instr_i),
    .imem_we_o(imem_we_o),
    .imem_addr_o(imem_addr_o),
    .imem_wdata_o(imem_wdata_o),
    .cpu_rst_o(cpu_rst_o),
    .load_done_o(load_done_o),
    .word_cnt_o(word_cnt_o)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum_o(checksum_o),
    .checksum_ok_o(checksum_ok_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    instr_i = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_wr, input logic [5:0] a);
    if (expect_wr) begin
      exp_addr.push_back(a);
      exp_data.push_back(w);
    end
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    instr_i = 8'h00;
    @(posedge clk_i);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    {31'd0, imem_we_o},   32'd0);
    chk({tag, "_addr"},  {26'd0, imem_addr_o}, 32'd0);
    chk({tag, "_wdata"}, imem_wdata_o,         32'd0);
    chk({tag, "_cpurst"}, {31'd0, cpu_rst_o},  32'd1);
    chk({tag, "_done"},  {31'd0, load_done_o}, 32'd0);
    chk({tag, "_cnt"},   {25'd0, word_cnt_o},  32'd0);
  endtask

  // Write monitor: every write pulse pops the scoreboard; back-to-back pulses are illegal.
  initial begin
    prev_we = 1'b0;
    while (!sim_end) begin
      @(negedge clk_i);
      if (!reset && imem_we_o) begin
        chk("we_gap", {31'd0, prev_we}, 32'd0);
        if (exp_addr.size() == 0) begin
          chk("unexpected_write_addr", {26'd0, imem_addr_o}, 32'hFFFF_FFFF);
        end else begin
          chk("wr_addr", {26'd0, imem_addr_o}, {26'd0, exp_addr.pop_front()});
          chk("wr_data", imem_wdata_o, exp_data.pop_front());
        end
      end
      prev_we = imem_we_o;
    end
  end

  initial begin
    logic [7:0] t1 [11];
    total   = 0;
    bad     = 0;
    sim_end = 1'b0;
    reset   = 1'b1;
    instr_i = 8'h00;
    @(posedge clk_i);
    #1;
    do_reset();
    chk_reset_vals("rst");

    // Test 1: leading junk, marker, one word, end marker.
    t1 = '{8'h00, 8'h00, 8'hFE, 8'h00, 8'h50, 8'h00, 8'h93, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_addr.push_back(6'd0);
    exp_data.push_back(32'h0050_0093);
    for (int i = 0; i < 11; i++) begin
      send_byte(t1[i]);
    end
    chk("t1_done_early", {31'd0, load_done_o}, 32'd0);
    send_byte(8'h00);
    chk("t1_done", {31'd0, load_done_o}, 32'd1);
    chk("t1_cpurst", {31'd0, cpu_rst_o}, 32'd0);
    chk("t1_cnt", {25'd0, word_cnt_o}, 32'd1);
    chk("t1_sb_empty", exp_addr.size(), 32'd0);

    // Test 2: embedded FF/FE bytes and a START_BYTE inside the load are data.
    do_reset();
    send_byte(8'hFE);
    send_word(32'hFFF0_0093, 1'b1, 6'd0);
    send_word(32'h00FE_0113, 1'b1, 6'd1);
    send_word(32'hFEFE_FEFE, 1'b1, 6'd2);
    send_word(32'hFFFF_FFFF, 1'b0, 6'd0);
    send_byte(8'h00);
    chk("t2_done", {31'd0, load_done_o}, 32'd1);
    chk("t2_cnt", {25'd0, word_cnt_o}, 32'd3);
    send_word(32'h0123_4567, 1'b0, 6'd0);
    chk("t2_cnt_hold", {25'd0, word_cnt_o}, 32'd3);

    // Test 3: fill all 64 words with no end marker.
    do_reset();
    send_byte(8'hFE);
    for (int i = 0; i < 64; i++) begin
      send_word(32'h1000_0000 + 32'(i) * 32'h0101, 1'b1, 6'(i));
    end
    send_word(32'hAAAA_5555, 1'b0, 6'd0);
    send_word(32'h1234_5678, 1'b0, 6'd0);
    chk("t3_done", {31'd0, load_done_o}, 32'd1);
    chk("t3_cpurst", {31'd0, cpu_rst_o}, 32'd0);
    chk("t3_cnt", {25'd0, word_cnt_o}, 32'd64);
    chk("t3_sb_empty", exp_addr.size(), 32'd0);

    // Test 4: reset in the middle of a word aborts the load.
    do_reset();
    send_byte(8'hFE);
    send_word(32'h0A0B_0C0D, 1'b1, 6'd0);
    send_word(32'h1A1B_1C1D, 1'b1, 6'd1);
    send_byte(8'h2A);
    send_byte(8'h2B);
    do_reset();
    chk_reset_vals("t4_rst");
    send_byte(8'hFE);
    send_word(32'hDEAD_BEEF, 1'b1, 6'd0);
    send_byte(8'h00);
    chk("t4_cnt", {25'd0, word_cnt_o}, 32'd1);
    chk("t4_done", {31'd0, load_done_o}, 32'd0);
    chk("t4_cpurst", {31'd0, cpu_rst_o}, 32'd1);

    // Test 5: no start marker for 50 cycles.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      send_byte(8'h00);
    end
    chk("t5_cpurst", {31'd0, cpu_rst_o}, 32'd1);
    chk("t5_done", {31'd0, load_done_o}, 32'd0);
    chk("t5_cnt", {25'd0, word_cnt_o}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Test 6: sender-appended checksum word, good and bad.
    do_reset();
    send_byte(8'hFE);
    send_word(32'h1111_1111, 1'b1, 6'd0);
    send_word(32'h2222_2222, 1'b1, 6'd1);
    send_word(32'h3333_3333, 1'b1, 6'd2);
    send_word(32'hFFFF_FFFF, 1'b0, 6'd0);
    send_byte(8'h00);
    chk("t6_cks", checksum_o, 32'h0000_0000);
    chk("t6_ok", {31'd0, checksum_ok_o}, 32'd1);
    do_reset();
    send_byte(8'hFE);
    send_word(32'h1111_1111, 1'b1, 6'd0);
    send_word(32'h2222_2222, 1'b1, 6'd1);
    send_word(32'h3333_3330, 1'b1, 6'd2);
    send_word(32'hFFFF_FFFF, 1'b0, 6'd0);
    send_byte(8'h00);
    chk("t6b_cks", checksum_o, 32'h0000_0003);
    chk("t6b_ok", {31'd0, checksum_ok_o}, 32'd0);
`endif

    send_byte(8'h00);
    send_byte(8'h00);
    chk("final_sb_empty", exp_addr.size(), 32'd0);
    sim_end = 1'b1;
    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
